// File: rtl/timer_pkg.sv
// Shared definitions for the APB timer sequencer: register map, register bit
// positions, clock-select codes, FSM state encodings and a TCR word builder.
package timer_pkg;

    localparam logic [7:0] TdrAddr = 8'h00;
    localparam logic [7:0] TcrAddr = 8'h01;
    localparam logic [7:0] TsrAddr = 8'h02;

    // TCR bit positions
    localparam int unsigned TcrLoad  = 7;
    localparam int unsigned TcrDown  = 5;
    localparam int unsigned TcrEn    = 4;
    localparam int unsigned TcrCksHi = 1;
    localparam int unsigned TcrCksLo = 0;

    // TSR bit positions
    localparam int unsigned TsrOvf = 0;
    localparam int unsigned TsrUdf = 1;
    localparam logic [7:0]  TsrFlags = (8'h01 << TsrOvf) | (8'h01 << TsrUdf);

    // Clock-select encodings
    localparam logic [1:0] CksClk2  = 2'b00;
    localparam logic [1:0] CksClk4  = 2'b01;
    localparam logic [1:0] CksClk8  = 2'b10;
    localparam logic [1:0] CksClk16 = 2'b11;

    typedef logic [3:0] state_t;
    localparam state_t StIdle     = 4'd0;
    localparam state_t StWTdr     = 4'd1;
    localparam state_t StWLoad    = 4'd2;
    localparam state_t StWRun     = 4'd3;
    localparam state_t StPollWait = 4'd4;
    localparam state_t StRTsr     = 4'd5;
    localparam state_t StWClr     = 4'd6;
    localparam state_t StWStop    = 4'd7;
    localparam state_t StDone     = 4'd8;

    function automatic logic [7:0] tcr_word(input logic load, input logic down,
                                            input logic en, input logic [1:0] cks);
        logic [7:0] w;
        w                    = 8'h00;
        w[TcrLoad]           = load;
        w[TcrDown]           = down;
        w[TcrEn]             = en;
        w[TcrCksHi:TcrCksLo] = cks;
        return w;
    endfunction

endpackage

// File: rtl/timer_apb_sequencer_if.sv
// APB bus between the sequencer (master) and the timer (slave).
interface timer_apb_sequencer_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_if.sv
// Single-transfer APB master: turns a level req into one SETUP/ACCESS transfer
// and returns a one-cycle ack with the captured read data and error flag.
module apb_master_if (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       req,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       slverr,
    timer_apb_sequencer_if.master apb
);

    logic       psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [7:0] paddr_q, paddr_d, pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic       ack_q, ack_d, slverr_q, slverr_d;

    // Phase sequencing; a req still high during the ack cycle is not re-issued,
    // which also guarantees an idle cycle between transfers.
    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        ack_d     = 1'b0;
        if (!psel_q) begin
            if (req && !ack_q) begin
                psel_d   = 1'b1;
                pwrite_d = wr;
                paddr_d  = addr;
                pwdata_d = wdata;
            end
        end else if (!penable_q) begin
            penable_d = 1'b1;
        end else if (apb.pready) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            ack_d     = 1'b1;
            rdata_d   = apb.prdata;
            slverr_d  = apb.pslverr;
        end
    end

    // Bus and response registers; reset drops the bus at once.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= 8'h00;
            pwdata_q  <= 8'h00;
            rdata_q   <= 8'h00;
            slverr_q  <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            ack_q     <= ack_d;
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign slverr      = slverr_q;

endmodule

// File: rtl/timer_apb_sequencer.sv
// Autonomous timer driver: programs TDR/TCR, polls TSR, clears and counts
// overflow/underflow events until the target count or a stop request.
module timer_apb_sequencer
    import timer_pkg::*;
#(
    parameter int unsigned POLL_GAP = 4,
    parameter logic [7:0]  TDR_ADDR = TdrAddr,
    parameter logic [7:0]  TCR_ADDR = TcrAddr,
    parameter logic [7:0]  TSR_ADDR = TsrAddr
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] cfg_tdr,
    input  logic       cfg_down,
    input  logic [1:0] cfg_cks,
    input  logic [7:0] cfg_nevt,
    timer_apb_sequencer_if.master apb,
    output logic       busy,
    output logic       done,
    output logic       evt,
    output logic [7:0] evt_cnt,
    output logic       err
);

    localparam int unsigned    GapW    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(POLL_GAP - 1);

    state_t          state_q, state_d;
    logic [7:0]      tdr_q, tdr_d, nevt_q, nevt_d, evt_cnt_q, evt_cnt_d;
    logic            down_q, down_d, err_q, err_d, stop_pend_q, stop_pend_d;
    logic [1:0]      cks_q, cks_d;
    logic [GapW-1:0] gap_q, gap_d;

    logic       req, wr, ack, slverr, stop_req, last_evt;
    logic [7:0] addr, wdata, rdata;

    apb_master_if u_apb (
        .pclk   (pclk),
        .presetn(presetn),
        .req    (req),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .ack    (ack),
        .rdata  (rdata),
        .slverr (slverr),
        .apb    (apb)
    );

    // A stop seen this cycle acts immediately alongside an earlier latched one.
    assign stop_req = stop_pend_q | stop;
    assign last_evt = (nevt_q != 8'h00) && (({1'b0, evt_cnt_q} + 9'd1) == {1'b0, nevt_q});

    // Sequencing FSM; each transfer state holds req until its ack.
    always_comb begin
        state_d     = state_q;
        tdr_d       = tdr_q;
        down_d      = down_q;
        cks_d       = cks_q;
        nevt_d      = nevt_q;
        evt_cnt_d   = evt_cnt_q;
        err_d       = err_q | (ack & slverr);
        stop_pend_d = stop_pend_q | (stop & (state_q != StIdle));
        gap_d       = '0;
        req         = 1'b0;
        wr          = 1'b1;
        addr        = TDR_ADDR;
        wdata       = 8'h00;
        case (state_q)
            StIdle: begin
                if (start) begin
                    tdr_d       = cfg_tdr;
                    down_d      = cfg_down;
                    cks_d       = cfg_cks;
                    nevt_d      = cfg_nevt;
                    evt_cnt_d   = 8'h00;
                    err_d       = 1'b0;
                    stop_pend_d = 1'b0;
                    state_d     = StWTdr;
                end
            end
            StWTdr: begin
                req   = 1'b1;
                wdata = tdr_q;
                if (ack) state_d = stop_req ? StWStop : StWLoad;
            end
            StWLoad: begin
                req   = 1'b1;
                addr  = TCR_ADDR;
                wdata = tcr_word(1'b1, down_q, 1'b0, cks_q);
                if (ack) state_d = stop_req ? StWStop : StWRun;
            end
            StWRun: begin
                req   = 1'b1;
                addr  = TCR_ADDR;
                wdata = tcr_word(1'b0, down_q, 1'b1, cks_q);
                if (ack) state_d = stop_req ? StWStop : StPollWait;
            end
            StPollWait: begin
                if (stop_req)              state_d = StWStop;
                else if (gap_q == GapLast) state_d = StRTsr;
                else                       gap_d   = gap_q + 1'b1;
            end
            StRTsr: begin
                req  = 1'b1;
                wr   = 1'b0;
                addr = TSR_ADDR;
                if (ack) begin
                    if (stop_req)                          state_d = StWStop;
                    else if ((rdata & TsrFlags) != 8'h00)  state_d = StWClr;
                    else                                   state_d = StPollWait;
                end
            end
            StWClr: begin
                req  = 1'b1;
                addr = TSR_ADDR;
                if (ack) begin
                    evt_cnt_d = (evt_cnt_q == 8'hFF) ? 8'hFF : evt_cnt_q + 8'd1;
                    state_d   = (stop_req || last_evt) ? StWStop : StPollWait;
                end
            end
            StWStop: begin
                req   = 1'b1;
                addr  = TCR_ADDR;
                wdata = tcr_word(1'b0, down_q, 1'b0, cks_q);
                if (ack) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and configuration registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= StIdle;
            tdr_q       <= 8'h00;
            down_q      <= 1'b0;
            cks_q       <= 2'b00;
            nevt_q      <= 8'h00;
            evt_cnt_q   <= 8'h00;
            err_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            tdr_q       <= tdr_d;
            down_q      <= down_d;
            cks_q       <= cks_d;
            nevt_q      <= nevt_d;
            evt_cnt_q   <= evt_cnt_d;
            err_q       <= err_d;
            stop_pend_q <= stop_pend_d;
            gap_q       <= gap_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign evt     = (state_q == StWClr) && ack;
    assign evt_cnt = evt_cnt_q;
    assign err     = err_q;

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// Directed bench: a small timer slave model answers the APB bus, a scoreboard
// queue holds the expected transfers, and status outputs are checked per run.
module tb_timer_apb_sequencer;
    import timer_pkg::*;

    logic       pclk = 1'b0, presetn = 1'b0, start = 1'b0, stop = 1'b0;
    logic [7:0] cfg_tdr = 8'h00, cfg_nevt = 8'h00;
    logic       cfg_down = 1'b0;
    logic [1:0] cfg_cks = 2'b00;
    logic       busy, done, evt, err;
    logic [7:0] evt_cnt;

    int checks = 0;
    int errors = 0;

    timer_apb_sequencer_if apb ();

    timer_apb_sequencer dut (
        .pclk    (pclk),
        .presetn (presetn),
        .start   (start),
        .stop    (stop),
        .cfg_tdr (cfg_tdr),
        .cfg_down(cfg_down),
        .cfg_cks (cfg_cks),
        .cfg_nevt(cfg_nevt),
        .apb     (apb),
        .busy    (busy),
        .done    (done),
        .evt     (evt),
        .evt_cnt (evt_cnt),
        .err     (err)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tb_tcr(input logic load, input logic down, input logic en,
                                          input logic [1:0] cks);
        return {load, 1'b0, down, en, 2'b00, cks};
    endfunction

    // ---------------- timer slave model ----------------
    bit         stall_tdr = 0, slverr_load = 0;
    int         poll_period = 1, wait_cnt = 0, rd_cnt = 0;
    logic [7:0] tcr_m = 8'h00;
    wire        access = apb.psel && apb.penable;

    assign apb.pready  = access && (wait_cnt == 0);
    assign apb.pslverr = apb.pready && slverr_load && apb.pwrite && (apb.paddr == TcrAddr)
                         && apb.pwdata[TcrLoad];
    // The poll_period-th TSR read after a TCR write or TSR clear shows the flag.
    assign apb.prdata  = (apb.paddr == TsrAddr && rd_cnt >= poll_period - 1)
                         ? (tcr_m[TcrDown] ? 8'h02 : 8'h01) : 8'h00;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt <= 0;
            rd_cnt   <= 0;
            tcr_m    <= 8'h00;
        end else begin
            if (apb.psel && !apb.penable)
                wait_cnt <= (stall_tdr && apb.paddr == TdrAddr) ? 5 : 0;
            else if (access && wait_cnt > 0)
                wait_cnt <= wait_cnt - 1;
            if (apb.pready) begin
                if (!apb.pwrite && apb.paddr == TsrAddr) rd_cnt <= rd_cnt + 1;
                else if (apb.pwrite && apb.paddr == TsrAddr) rd_cnt <= 0;
                else if (apb.pwrite && apb.paddr == TcrAddr) begin
                    tcr_m  <= apb.pwdata;
                    rd_cnt <= 0;
                end
            end
        end
    end

    // ---------------- scoreboard / bus monitor ----------------
    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } xfer_t;

    xfer_t       exp_q[$];
    xfer_t       mon_e;
    logic [16:0] su_snap = '0;
    bit          prev_cmp = 0;
    int          evt_seen = 0;

    always @(negedge pclk) begin
        if (presetn && apb.psel) begin
            if (!apb.penable) begin
                chk("apb_gap", prev_cmp, 1'b0);
                su_snap <= {apb.pwrite, apb.paddr, apb.pwdata};
            end else begin
                chk("apb_hold", {apb.pwrite, apb.paddr, apb.pwdata}, su_snap);
                if (apb.pready) begin
                    chk("sb_nonempty", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("apb_write", apb.pwrite, mon_e.wr);
                        chk("apb_addr", apb.paddr, mon_e.addr);
                        if (mon_e.wr) chk("apb_wdata", apb.pwdata, mon_e.data);
                    end
                end
            end
        end
        prev_cmp <= presetn && apb.psel && apb.penable && apb.pready;
        if (presetn && evt) evt_seen <= evt_seen + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        exp_q.push_back('{wr: wr, addr: addr, data: data});
    endtask

    task automatic push_seq(input logic [7:0] tdr, input logic down, input logic [1:0] cks,
                            input int n_evt, input int period);
        push(1'b1, TdrAddr, tdr);
        push(1'b1, TcrAddr, tb_tcr(1'b1, down, 1'b0, cks));
        push(1'b1, TcrAddr, tb_tcr(1'b0, down, 1'b1, cks));
        for (int e = 0; e < n_evt; e++) begin
            for (int r = 0; r < period; r++) push(1'b0, TsrAddr, 8'h00);
            push(1'b1, TsrAddr, 8'h00);
        end
        push(1'b1, TcrAddr, tb_tcr(1'b0, down, 1'b0, cks));
    endtask

    task automatic do_start(input logic [7:0] tdr, input logic down, input logic [1:0] cks,
                            input logic [7:0] nevt);
        @(negedge pclk);
        cfg_tdr  = tdr;
        cfg_down = down;
        cfg_cks  = cks;
        cfg_nevt = nevt;
        start    = 1'b1;
        @(negedge pclk);
        start    = 1'b0;
    endtask

    task automatic wait_sig(input string tag, input bit want_done);
        bit seen = 0;
        for (int n = 0; n < 5000 && !seen; n++) begin
            @(negedge pclk);
            seen = want_done ? done : evt;
        end
        chk(tag, seen, 1'b1);
    endtask

    task automatic end_checks(input string tag, input logic [7:0] cnt, input logic e,
                              input int ev0, input int nev);
        chk({tag, "_evt_cnt"}, evt_cnt, cnt);
        chk({tag, "_err"}, err, e);
        chk({tag, "_busy_in_done"}, busy, 1'b1);
        @(negedge pclk);
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_evt_pulses"}, evt_seen - ev0, nev);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ev0;
        bit hit;

        repeat (3) @(negedge pclk);
        chk("rst_apb", {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata}, 0);
        chk("rst_status", {busy, done, evt, err, evt_cnt}, 0);
        presetn = 1'b1;

        // Count up, clk2, one event
        poll_period = 3;
        ev0 = evt_seen;
        push_seq(8'h00, 1'b0, CksClk2, 1, 3);
        do_start(8'h00, 1'b0, CksClk2, 8'd1);
        chk("t1_busy", busy, 1'b1);
        wait_sig("t1_done", 1'b1);
        end_checks("t1", 8'd1, 1'b0, ev0, 1);

        // Count down, clk4, three events; a start while busy is ignored
        poll_period = 2;
        ev0 = evt_seen;
        push_seq(8'h05, 1'b1, CksClk4, 3, 2);
        do_start(8'h05, 1'b1, CksClk4, 8'd3);
        wait_sig("t2_evt1", 1'b0);
        do_start(8'hAA, 1'b0, CksClk16, 8'd1);
        chk("t2_cnt_kept", evt_cnt, 8'd1);
        wait_sig("t2_done", 1'b1);
        end_checks("t2", 8'd3, 1'b0, ev0, 3);

        // Run-until-stop, stop right after the second event
        ev0 = evt_seen;
        push_seq(8'h10, 1'b0, CksClk8, 2, 2);
        do_start(8'h10, 1'b0, CksClk8, 8'd0);
        chk("t3_cnt_cleared", evt_cnt, 8'd0);
        wait_sig("t3_evt1", 1'b0);
        wait_sig("t3_evt2", 1'b0);
        stop = 1'b1;
        @(negedge pclk);
        stop = 1'b0;
        wait_sig("t3_done", 1'b1);
        end_checks("t3", 8'd2, 1'b0, ev0, 2);

        // Stalled TDR write and slave error on the load write
        stall_tdr   = 1;
        slverr_load = 1;
        poll_period = 1;
        ev0 = evt_seen;
        push_seq(8'h33, 1'b0, CksClk2, 1, 1);
        do_start(8'h33, 1'b0, CksClk2, 8'd1);
        wait_sig("t4_done", 1'b1);
        end_checks("t4", 8'd1, 1'b1, ev0, 1);
        chk("t4_err_sticky", err, 1'b1);
        stall_tdr   = 0;
        slverr_load = 0;

        // New start clears err; reset while polling drops everything at once
        poll_period = 40;
        push_seq(8'h44, 1'b0, CksClk2, 1, 40);
        do_start(8'h44, 1'b0, CksClk2, 8'd1);
        chk("t5_err_cleared", err, 1'b0);
        hit = 0;
        for (int n = 0; n < 2000 && !hit; n++) begin
            @(negedge pclk);
            hit = apb.psel && (apb.paddr == TsrAddr);
        end
        chk("t5_reach_poll", hit, 1'b1);
        #2 presetn = 1'b0;
        #1;
        chk("t5_rst_apb", {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata}, 0);
        chk("t5_rst_status", {busy, done, evt, err, evt_cnt}, 0);
        exp_q.delete();
        poll_period = 1;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;

        // Full sequence again from the TDR write
        ev0 = evt_seen;
        push_seq(8'h7E, 1'b1, CksClk16, 1, 1);
        do_start(8'h7E, 1'b1, CksClk16, 8'd1);
        wait_sig("t6_done", 1'b1);
        end_checks("t6", 8'd1, 1'b0, ev0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
